// File: rtl/serial_addsub4.sv
// Bit-serial 4-bit adder/subtractor: one bit per clock, LSB first, fixed 4-cycle latency.
// Optional signed-overflow output ovf is built only when SERIAL_ADDSUB4_OVF_EN is defined.
module serial_addsub4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sub,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       busy,
  output logic       done,
  output logic [3:0] sum,
  output logic       cout
`ifdef SERIAL_ADDSUB4_OVF_EN
  ,
  output logic       ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start; last result held on sum/cout
  // RUN   | one operand bit per edge, bits_left counts down to terminal 0
  // DONE  | result just loaded, done high for this cycle; start here chains a new op
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] a_sh;
  logic [3:0] b_sh;
  logic [2:0] res_sh;
  logic       carry;
  logic [1:0] bits_left;
  logic       bit_sum;
  logic       bit_carry;

  always_comb begin
    bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= 4'd0;
      b_sh      <= 4'd0;
      res_sh    <= 3'd0;
      carry     <= 1'b0;
      bits_left <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= 4'd0;
      cout      <= 1'b0;
`ifdef SERIAL_ADDSUB4_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract is a + ~b + 1; cin only matters when adding.
            a_sh      <= a;
            b_sh      <= sub ? ~b : b;
            carry     <= sub ? 1'b1 : cin;
            res_sh    <= 3'd0;
            bits_left <= 2'd3;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[3:1]};
          b_sh   <= {1'b0, b_sh[3:1]};
          res_sh <= {bit_sum, res_sh[2:1]};
          carry  <= bit_carry;
          if (bits_left == 2'd0) begin
            sum   <= {bit_sum, res_sh};
            cout  <= bit_carry;
`ifdef SERIAL_ADDSUB4_OVF_EN
            // carry here is the carry into bit 3, bit_carry the carry out of it
            ovf   <= carry ^ bit_carry;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bits_left <= bits_left - 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub4.sv
// Self-checking bench for serial_addsub4: directed cases, exhaustive sweep and random ops
// against an arithmetic reference model; ovf checked when SERIAL_ADDSUB4_OVF_EN is defined.
module tb_serial_addsub4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       cout;
`ifdef SERIAL_ADDSUB4_OVF_EN
  logic       ovf;
`endif

  serial_addsub4 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDSUB4_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected held result (what sum/cout/ovf must show outside completion edges)
  logic [3:0] exp_sum;
  logic       exp_cout;
  logic       exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, signed range test for overflow.
  task automatic model(input int ai, input int bi, input int si, input int ci,
                       output logic [3:0] m_sum, output logic m_cout, output logic m_ovf);
    int eb, c0, r, sa, sb, sr;
    eb = si ? (15 - bi) : bi;
    c0 = si ? 1 : ci;
    r  = ai + eb + c0;
    m_sum  = 4'(r % 16);
    m_cout = (r >= 16);
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (eb >= 8) ? eb - 16 : eb;
    sr = sa + sb + c0;
    m_ovf = (sr > 7) || (sr < -8);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDSUB4_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // One operation; caller sits just after a posedge. Optionally re-pulse start mid-run,
  // optionally follow with an idle cycle (otherwise the next op chains from DONE).
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                       input logic ci, input bit restart, input bit idle_after);
    logic [3:0] m_sum;
    logic       m_cout, m_ovf;
    int         busy_cnt;
    model(int'(ai), int'(bi), int'(si), int'(ci), m_sum, m_cout, m_ovf);
    @(negedge clk);
    a = ai; b = bi; sub = si; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    busy_cnt = 0;
    if (busy) busy_cnt++;
    check("busy_on", 32'(busy), 32'd1);
    check("done_run", 32'(done), 32'd0);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 4; k++) begin
      if (restart && k == 2) begin
        a = 4'hf; b = 4'hf; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < 4) begin
        if (busy) busy_cnt++;
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
        check_outputs("hold_run");
      end
    end
    exp_sum = m_sum; exp_cout = m_cout; exp_ovf = m_ovf;
    check("busy_cycles", 32'(busy_cnt), 32'd4);
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check_outputs("result");
    if (idle_after) begin
      @(posedge clk); #1;
      check("done_clear", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check_outputs("hold_idle");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    exp_sum = 4'd0; exp_cout = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_outputs("rst");
    // start held with reset must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    check("rst_prio_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(4'b0111, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
    check("dir1_sum", 32'(sum), 32'b1101);
    do_op(4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    check("dir2_sum", 32'(sum), 32'b0001);
    do_op(4'b0101, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
    check("dir3_sum", 32'(sum), 32'b0010);
    do_op(4'b0011, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1);
    check("dir4_sum", 32'(sum), 32'b1110);
    check("dir4_cout", 32'(cout), 32'd0);
    do_op(4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1);
    check("restart_sum", 32'(sum), 32'b0110);

    // Reset on the second RUN cycle aborts the operation
    @(negedge clk);
    a = 4'd9; b = 4'd3; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sum = 4'd0; exp_cout = 1'b0; exp_ovf = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_outputs("abort");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    do_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);

    // Exhaustive sweep: add cin=0, add cin=1, subtract
    for (int m = 0; m < 3; m++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          do_op(4'(ai), 4'(bi), (m == 2), (m == 1), 1'b0, ((ai + bi) % 3 == 0));

    for (int n = 0; n < 150; n++)
      do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub4.md
SERIAL_ADDSUB4 -- requirements
Module: serial_addsub4

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-004 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-005 The block SHALL have port a, input, 4 bits: operand A, unsigned/two's complement.
REQ-006 The block SHALL have port b, input, 4 bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, add mode only.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, 4 bits: result.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out; in subtract mode 1 = no borrow (a >= b unsigned).
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow, present only per REQ-030.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b, sub and cin into internal shift registers, clear the bit counter and enter RUN.
REQ-015 On capture, the effective B SHALL be ~b when sub=1 and b otherwise; the initial carry SHALL be 1 when sub=1 and cin otherwise; cin SHALL be ignored when sub=1.
REQ-016 In RUN, each rising edge SHALL process exactly one bit, LSB first: a one-bit full add of A[i], effBi and carry, shifting the sum bit into the result register and updating the carry flop.
REQ-017 After the fourth RUN edge, the FSM SHALL enter DONE; sum and cout SHALL be final and done=1 for exactly one cycle.
REQ-018 From DONE without start, the FSM SHALL return to IDLE; done SHALL deassert.
REQ-019 Latency SHALL be fixed at 4 cycles: with start sampled at edge E0, done is high in the cycle following edge E4.
REQ-020 busy SHALL be 1 in RUN only; it SHALL be 0 in IDLE and DONE.
REQ-021 start while in RUN SHALL be ignored; the operation in flight and its operands SHALL be unaffected.
REQ-022 Changes to a, b, sub and cin after capture SHALL NOT affect the in-flight result.
REQ-023 sum and cout SHALL hold the last completed result until the next completion or reset; intermediate shift contents SHALL NOT be visible on sum.
REQ-024 Arithmetic SHALL be modulo 16 on sum, with cout = bit 4 of a + effB + carry0.
REQ-025 Back-to-back operation SHALL be supported: start during DONE begins a new operation with no idle cycle, and done still pulses for the completed one.

Reset
REQ-026 While rst=1 at a rising edge, the FSM SHALL enter IDLE and busy, done, sum, cout and ovf SHALL all become 0.
REQ-027 rst SHALL take priority over start.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL complete normally.

Configuration
REQ-029 The block SHALL use the macro SERIAL_ADDSUB4_OVF_EN.
REQ-030 When SERIAL_ADDSUB4_OVF_EN is defined, port ovf SHALL exist and, at completion, be loaded with (carry into bit 3) XOR (carry out of bit 3), held like sum, and reset to 0.
REQ-031 When SERIAL_ADDSUB4_OVF_EN is undefined, ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Add: a=0111, b=0110, cin=0, sub=0, start pulse -> done exactly 4 cycles later with sum=1101, cout=0, ovf=1 (macro on).
REQ-033 Add with carry: a=1111, b=0001, cin=1 -> sum=0001, cout=1, ovf=0.
REQ-034 Subtract: a=0101, b=0011, sub=1, cin=1 -> sum=0010, cout=1; then a=0011, b=0101 back-to-back from DONE -> sum=1110, cout=0, ovf=0.
REQ-035 Start re-pulsed during RUN with a=1111, b=1111 -> ignored; exactly one done with the original result; busy=1 for exactly 4 cycles.
REQ-036 rst pulsed on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0000, cout=0; no done follows; a fresh start then yields a correct result.
REQ-037 Exhaustive check of all a, b (16x16) for sub=0 with cin 0/1 and sub=1 against the reference model {cout,sum} = a + effB + carry0, with the macro both defined and undefined.
